// File: rtl/inst_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache_assoc
// Brief    : Set-associative instruction cache, round-robin refill and uncached window.
// Revision : 1.0
// ============================================================================
module inst_cache_assoc #(
    parameter int          WAYS          = 2,
    parameter int          SETS          = 32,
    parameter int          LINE_BITS     = 256,
    parameter logic [31:0] UNCACHED_MASK = 32'hFFFF_F000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          inst_addr_i,
    output logic [31:0]          inst_data_o,
    output logic                 inst_valid_o,
    input  logic                 mem_fc,
    output logic                 hw_page_fault_o,
    output logic [31:0]          uncached_addr_o,
    input  logic [31:0]          uncached_data_i,
    output logic                 uncached_rd_o,
    input  logic                 uncached_ack_i,
    output logic [31:0]          addr_o,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 rd_o,
    input  logic                 ack_i,
    input  logic                 hw_page_fault_i
);

    localparam int c_off = $clog2(LINE_BITS / 8);
    localparam int c_idx = $clog2(SETS);
    localparam int c_tag = 32 - c_off - c_idx;
    localparam int c_wb  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [c_wb-1:0] c_rr_last = c_wb'(WAYS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t               r_state;
    logic [31:0]          r_addr;
    logic                 r_rd;
    logic                 r_fault;
    logic                 r_flush_pending;
    logic [c_wb-1:0]      r_victim;
    logic [WAYS-1:0]      r_valid [SETS];
    logic [c_tag-1:0]     r_tag   [SETS][WAYS];
    logic [LINE_BITS-1:0] r_data  [SETS][WAYS];
    logic [c_wb-1:0]      r_rr    [SETS];

    logic [c_idx-1:0]     w_idx;
    logic [c_tag-1:0]     w_tag;
    logic [c_off-3:0]     w_word;
    logic [c_idx-1:0]     w_fill_idx;
    logic [c_tag-1:0]     w_fill_tag;
    logic                 w_uncached;
    logic                 w_hit;
    logic [c_wb-1:0]      w_hit_way;
    logic [c_wb-1:0]      w_victim;
    logic [LINE_BITS-1:0] w_line;

    assign w_idx      = inst_addr_i[c_off +: c_idx];
    assign w_tag      = inst_addr_i[31 -: c_tag];
    assign w_word     = inst_addr_i[c_off-1:2];
    assign w_fill_idx = r_addr[c_off +: c_idx];
    assign w_fill_tag = r_addr[31 -: c_tag];
    assign w_uncached = (inst_addr_i & UNCACHED_MASK) == UNCACHED_MASK;

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_wb'(w);
            end
        end
    end

    // Lowest invalid way first, otherwise the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim = c_wb'(w);
            end
        end
    end

    assign w_line = r_data[w_idx][w_hit_way];

    assign uncached_rd_o   = w_uncached;
    assign uncached_addr_o = w_uncached ? inst_addr_i : 32'h0;
    assign inst_valid_o    = w_uncached ? uncached_ack_i : w_hit;
    assign inst_data_o     = w_uncached ? uncached_data_i :
                             (w_hit ? w_line[{w_word, 5'd0} +: 32] : 32'h0);
    assign addr_o          = r_addr;
    assign rd_o            = r_rd;
    assign hw_page_fault_o = r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_rd            <= 1'b0;
            r_fault         <= 1'b0;
            r_flush_pending <= 1'b0;
            r_victim        <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tag[s][w] <= '0;
                end
            end
        end else begin
            r_fault <= 1'b0;
            if (mem_fc) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_uncached && !w_hit) begin
                        r_addr   <= {inst_addr_i[31:c_off], {c_off{1'b0}}};
                        r_rd     <= 1'b1;
                        r_victim <= w_victim;
                        r_state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_fc) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (ack_i) begin
                        // A flush seen at any point of the fill leaves the line invalid.
                        r_tag[w_fill_idx][r_victim]   <= w_fill_tag;
                        r_valid[w_fill_idx][r_victim] <= ~hw_page_fault_i & ~r_flush_pending & ~mem_fc;
                        r_rr[w_fill_idx]              <= (r_rr[w_fill_idx] == c_rr_last) ?
                                                         '0 : r_rr[w_fill_idx] + 1'b1;
                        r_fault         <= hw_page_fault_i;
                        r_rd            <= 1'b0;
                        r_addr          <= '0;
                        r_flush_pending <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_FILL) && ack_i) begin
            r_data[w_fill_idx][r_victim] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_cache_assoc
// Brief    : Scoreboard bench for inst_cache_assoc with directed fetch/fill vectors.
// Revision : 1.0
// ============================================================================
module tb_inst_cache_assoc;

    localparam int          LINE_BITS = 256;
    localparam logic [31:0] IDLE_A    = 32'hFFFF_F000;
    localparam int          K_FILL    = 1;
    localparam int          K_FAULT   = 2;
    localparam int          K_DATA    = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          inst_addr_i;
    logic [31:0]          inst_data_o;
    logic                 inst_valid_o;
    logic                 mem_fc;
    logic                 hw_page_fault_o;
    logic [31:0]          uncached_addr_o;
    logic [31:0]          uncached_data_i;
    logic                 uncached_rd_o;
    logic                 uncached_ack_i;
    logic [31:0]          addr_o;
    logic [LINE_BITS-1:0] data_i;
    logic                 rd_o;
    logic                 ack_i;
    logic                 hw_page_fault_i;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_rd = 1'b0;

    inst_cache_assoc #(
        .WAYS(2), .SETS(32), .LINE_BITS(LINE_BITS), .UNCACHED_MASK(32'hFFFF_F000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
        .inst_valid_o(inst_valid_o), .mem_fc(mem_fc), .hw_page_fault_o(hw_page_fault_o),
        .uncached_addr_o(uncached_addr_o), .uncached_data_i(uncached_data_i),
        .uncached_rd_o(uncached_rd_o), .uncached_ack_i(uncached_ack_i),
        .addr_o(addr_o), .data_i(data_i), .rd_o(rd_o), .ack_i(ack_i),
        .hw_page_fault_i(hw_page_fault_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endfunction

    task automatic take(input int k, input logic [31:0] v, input string name);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected event value %h, none expected", name, v);
        end else begin
            e = q.pop_front();
            check({name, "_kind"}, k, e.kind);
            check(name, v, e.val);
        end
    endtask

    // Monitor: every DUT-presented event consumes the next scoreboard entry.
    always @(negedge clk) begin
        if (hw_page_fault_o === 1'b1) take(K_FAULT, 32'h0, "fault_pulse");
        if (rd_o === 1'b1 && prev_rd !== 1'b1) take(K_FILL, addr_o, "fill_req");
        if (inst_valid_o === 1'b1) take(K_DATA, inst_data_o, "inst_data");
        prev_rd = rd_o;
    end

    function automatic logic [LINE_BITS-1:0] mk_line(input logic [31:0] base);
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < LINE_BITS / 32; k++) begin
            l[k*32 +: 32] = base ^ (32'hA000_0000 | 32'(k));
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_word);
        push(K_DATA, exp_word);
        inst_addr_i = a;
        @(negedge clk);
        #1 inst_addr_i = IDLE_A;
        tick();
    endtask

    task automatic probe_miss(input logic [31:0] a);
        inst_addr_i = a;
        @(negedge clk);
        check("probe_miss", inst_valid_o, 1'b0);
        #1 inst_addr_i = IDLE_A;
        tick();
    endtask

    // Miss on a, wait lat cycles with rd_o up, then ack. flush_at: -1 none,
    // 0 at the ack cycle, k>0 in fill cycle k. keep leaves a on the bus afterwards.
    task automatic do_fill(input logic [31:0] a, input logic [LINE_BITS-1:0] line,
                           input logic fault, input int lat, input int flush_at,
                           input logic keep, input logic [31:0] exp_word);
        logic [31:0] la;
        logic        hit;
        la  = {a[31:5], 5'b0};
        hit = !fault && (flush_at < 0);
        push(K_FILL, la);
        if (fault) push(K_FAULT, 32'h0);
        if (hit) push(K_DATA, exp_word);
        inst_addr_i = a;
        @(negedge clk);
        check("miss_detect", inst_valid_o, 1'b0);
        tick();
        for (int c = 1; c < lat; c++) begin
            inst_addr_i = a + 32'h2000;
            mem_fc      = (flush_at == c);
            @(negedge clk);
            check("fill_hold_rd", rd_o, 1'b1);
            check("fill_hold_addr", addr_o, la);
            tick();
            mem_fc = 1'b0;
        end
        inst_addr_i     = a;
        data_i          = line;
        hw_page_fault_i = fault;
        mem_fc          = (flush_at == 0);
        ack_i           = 1'b1;
        tick();
        ack_i           = 1'b0;
        hw_page_fault_i = 1'b0;
        mem_fc          = 1'b0;
        data_i          = '0;
        @(negedge clk);
        check("post_fill_valid", inst_valid_o, hit);
        check("rd_drop", rd_o, 1'b0);
        check("addr_clear", addr_o, 32'h0);
        #1 if (!keep) inst_addr_i = IDLE_A;
        tick();
    endtask

    initial begin
        logic [LINE_BITS-1:0] l;
        rst_n = 1'b0; inst_addr_i = IDLE_A; mem_fc = 1'b0; uncached_data_i = '0;
        uncached_ack_i = 1'b0; data_i = '0; ack_i = 1'b0; hw_page_fault_i = 1'b0;
        repeat (3) tick();
        inst_addr_i = 32'h0000_0104;
        @(negedge clk);
        check("rst_rd", rd_o, 1'b0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_fault", hw_page_fault_o, 1'b0);
        check("rst_no_hit", inst_valid_o, 1'b0);
        #1 inst_addr_i = IDLE_A;
        tick();
        rst_n = 1'b1;
        tick();

        // Cold fetch, ack three cycles into the fill.
        l = mk_line(32'h0000_0100);
        l[63:32] = 32'hDEAD_BEEF;
        do_fill(32'h0000_0104, l, 1'b0, 3, -1, 1'b0, 32'hDEAD_BEEF);
        fetch(32'h0000_0104, 32'hDEAD_BEEF);

        // Three lines into set 0: third evicts way 0, round robin moves on.
        do_fill(32'h0000_0000, mk_line(32'h0), 1'b0, 2, -1, 1'b0, 32'hA000_0000);
        do_fill(32'h0000_0408, mk_line(32'h400), 1'b0, 1, -1, 1'b0, 32'hA000_0402);
        do_fill(32'h0000_080C, mk_line(32'h800), 1'b0, 1, -1, 1'b0, 32'hA000_0803);
        probe_miss(32'h0000_0000);
        fetch(32'h0000_0414, 32'hA000_0405);
        fetch(32'h0000_081C, 32'hA000_0807);
        do_fill(32'h0000_0000, mk_line(32'h0), 1'b0, 1, -1, 1'b0, 32'hA000_0000);
        probe_miss(32'h0000_0400);
        fetch(32'h0000_0800, 32'hA000_0800);

        // Uncached word: served straight through, no line fill.
        push(K_DATA, 32'h1234_5678);
        inst_addr_i = 32'hFFFF_F010; uncached_data_i = 32'h1234_5678; uncached_ack_i = 1'b1;
        @(negedge clk);
        check("unc_rd_req", uncached_rd_o, 1'b1);
        check("unc_addr", uncached_addr_o, 32'hFFFF_F010);
        check("unc_no_fill", rd_o, 1'b0);
        tick();
        uncached_ack_i = 1'b0; inst_addr_i = IDLE_A;
        @(negedge clk);
        check("unc_no_fill_after", rd_o, 1'b0);
        tick();

        // Faulting fill: one-cycle fault pulse, line invalid, request reissued.
        l = mk_line(32'h0000_1240);
        do_fill(32'h0000_1244, l, 1'b1, 2, -1, 1'b1, 32'h0);
        push(K_FILL, 32'h0000_1240);
        push(K_DATA, 32'hA000_1241);
        @(negedge clk);
        check("refill_req", rd_o, 1'b1);
        check("fault_one_cycle", hw_page_fault_o, 1'b0);
        #1 data_i = l; ack_i = 1'b1;
        tick();
        ack_i = 1'b0; data_i = '0;
        @(negedge clk);
        check("refill_hit", inst_valid_o, 1'b1);
        #1 inst_addr_i = IDLE_A;
        tick();

        // Flush during a fill: in-flight line and every older line invalid.
        l = mk_line(32'h0000_2020);
        do_fill(32'h0000_2024, l, 1'b0, 3, 1, 1'b1, 32'h0);
        push(K_FILL, 32'h0000_2020);
        push(K_DATA, 32'hA000_2021);
        data_i = l; ack_i = 1'b1;
        tick();
        ack_i = 1'b0; data_i = '0;
        @(negedge clk);
        #1 inst_addr_i = IDLE_A;
        tick();
        probe_miss(32'h0000_0104);
        probe_miss(32'h0000_0800);
        probe_miss(32'h0000_0000);
        probe_miss(32'h0000_1244);
        // Flush coincident with the ack.
        do_fill(32'h0000_3048, mk_line(32'h3040), 1'b0, 2, 0, 1'b0, 32'h0);
        probe_miss(32'h0000_3048);
        probe_miss(32'h0000_2024);

        // Reset mid-fill, then a stray ack.
        push(K_FILL, 32'h0000_4000);
        inst_addr_i = 32'h0000_4000;
        tick();
        tick();
        rst_n = 1'b0; inst_addr_i = IDLE_A;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_abandon_rd", rd_o, 1'b0);
        check("rst_abandon_addr", addr_o, 32'h0);
        #1 data_i = mk_line(32'h4000); ack_i = 1'b1;
        tick();
        ack_i = 1'b0; data_i = '0;
        @(negedge clk);
        check("late_ack_ignored", rd_o, 1'b0);
        check("late_ack_no_fault", hw_page_fault_o, 1'b0);
        #1;
        tick();
        probe_miss(32'h0000_4000);
        probe_miss(32'h0000_0104);
        @(negedge clk);
        check("stay_idle", rd_o, 1'b0);

        repeat (3) tick();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_event: kind %0d value %h expected, never seen", e.kind, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
